// File: rtl/shift_pkg.sv
// Shared definitions for the shift issue queue: op codes, field widths,
// the packed command layout and the legal-select helper.
package shift_pkg;

    localparam int DATA_W = 16;
    localparam int AMT_W  = 4;
    localparam int SEL_W  = 3;

    localparam logic [SEL_W-1:0] SHIFT_LSR = 3'b000;
    localparam logic [SEL_W-1:0] SHIFT_LSL = 3'b001;
    localparam logic [SEL_W-1:0] SHIFT_ROR = 3'b010;
    localparam logic [SEL_W-1:0] SHIFT_ROL = 3'b011;
    localparam logic [SEL_W-1:0] SHIFT_ASR = 3'b100;

    // Command fields in the order they are stored in the FIFO; the tag is
    // appended below this struct by the top because its width is a parameter.
    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [AMT_W-1:0]  amt;
        logic [DATA_W-1:0] operand;
    } shift_op_t;

    localparam int OP_W = $bits(shift_op_t);

    // Op codes above ASR (101..111) have no shifter meaning.
    function automatic logic is_legal_select(input logic [SEL_W-1:0] sel);
        return (sel <= SHIFT_ASR);
    endfunction

endpackage

// File: rtl/shift_cmd_fifo.sv
// Generic DEPTH x W synchronous FIFO with occupancy count and synchronous
// flush. DEPTH must be a power of two so the pointers wrap naturally.
// The head entry is read combinationally.
module shift_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wr_data,
    output logic [W-1:0]               rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_en;
    logic          pop_en;

    // Flush overrides both ports; a full FIFO refuses a push even if the
    // head leaves in the same cycle, so full never depends on pop.
    assign push_en = push && !full && !flush;
    assign pop_en  = pop && !empty && !flush;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Storage array write; contents need no reset because count gates reads.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/shift_issue_queue.sv
// Front-end for the datapath BarrelShifter: buffers shift commands, drives
// the shifter from the FIFO head and registers the shifted value with its
// tag into a valid/ready output stage. The shifter itself lives outside.
module shift_issue_queue
    import shift_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAGW  = 4
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Flush,
    input  logic              InValid,
    output logic              InReady,
    input  logic [SEL_W-1:0]  InSelect,
    input  logic [AMT_W-1:0]  InAmount,
    input  logic [DATA_W-1:0] InOperand,
    input  logic [TAGW-1:0]   InTag,
    output logic [SEL_W-1:0]  ShiftSelect,
    output logic [AMT_W-1:0]  ShifterAmount,
    output logic [DATA_W-1:0] OriginB,
    input  logic [DATA_W-1:0] ShiftedB,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] OutResult,
    output logic [TAGW-1:0]   OutTag,
    output logic              OutError
);

    localparam int W  = OP_W + TAGW;
    localparam int CW = $clog2(DEPTH) + 1;

    shift_op_t         in_op;
    shift_op_t         head_op;
    logic [TAGW-1:0]   head_tag;
    logic [W-1:0]      push_data;
    logic [W-1:0]      head_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     unused_fifo_count;
    logic              head_legal;
    logic              pop;

    logic              out_valid;
    logic [DATA_W-1:0] out_result;
    logic [TAGW-1:0]   out_tag;
    logic              out_error;

    assign in_op.sel     = InSelect;
    assign in_op.amt     = InAmount;
    assign in_op.operand = InOperand;
    assign push_data     = {in_op, InTag};

    assign head_op  = head_data[W-1 -: OP_W];
    assign head_tag = head_data[TAGW-1:0];

    shift_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk     (Clk),
        .rst_n   (Rst_n),
        .flush   (Flush),
        .push    (InValid),
        .pop     (pop),
        .wr_data (push_data),
        .rd_data (head_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (unused_fifo_count)
    );

    // InReady comes only from the registered count, never from OutReady.
    assign InReady    = !fifo_full;
    assign head_legal = is_legal_select(head_op.sel);

    // The head advances whenever the output register is free or draining.
    assign pop = !fifo_empty && (!out_valid || OutReady);

    // Head mux onto the shifter; an illegal select becomes a zero-amount LSR
    // so the operand passes through unchanged.
    always_comb begin
        ShiftSelect   = SHIFT_LSR;
        ShifterAmount = '0;
        OriginB       = '0;
        if (!fifo_empty) begin
            OriginB = head_op.operand;
            if (head_legal) begin
                ShiftSelect   = head_op.sel;
                ShifterAmount = head_op.amt;
            end
        end
    end

    // Output stage: capture the shifter result on pop, hold under back-pressure.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            out_error  <= 1'b0;
        end else if (Flush) begin
            out_valid <= 1'b0;
        end else if (pop) begin
            out_valid  <= 1'b1;
            out_result <= ShiftedB;
            out_tag    <= head_tag;
            out_error  <= !head_legal;
        end else if (OutReady) begin
            out_valid <= 1'b0;
        end
    end

    assign OutValid  = out_valid;
    assign OutResult = out_result;
    assign OutTag    = out_tag;
    assign OutError  = out_error;

endmodule
